// File: rtl/hazard_forward_unit_pkg.sv
// Shared types for the hazard/forwarding unit: shadow entry,
// FSM state encoding and the register-file select constant.
package hazard_forward_unit_pkg;

  // Widest register address a shadow entry can hold.
  localparam int RD_MAXW = 8;

  localparam int FWD_SEL_RF = 0;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT    = 2'd1,
    FLUSHED = 2'd2
  } hfu_state_e;

  typedef struct packed {
    logic               valid;
    logic               wr_en;
    logic               mem_read;
    logic [RD_MAXW-1:0] rd;
  } shadow_t;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Decode-side bundle of the hazard/forwarding unit.
// master: decode/pipeline control side, slave: the unit.
// With HFU_PERF_CNT_EN defined, stall_cnt[15:0] is added.
interface hazard_forward_unit_if #(
  parameter int REG_AW    = 3,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int SELW      = $clog2(FWD_DEPTH+1)
);

  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_used;
  logic [REG_AW-1:0]         id_rd;
  logic                      id_wr_en;
  logic                      id_mem_read;
  logic                      flush;
  logic                      mem_busy;
  logic [NUM_SRC*SELW-1:0]   fwd_sel;
  logic                      stall_if_id;
  logic                      bubble_ex;
  logic                      freeze;
  logic [1:0]                state;
`ifdef HFU_PERF_CNT_EN
  logic [15:0]               stall_cnt;

  modport master (
    output id_valid, id_src, id_src_used,
    output id_rd, id_wr_en, id_mem_read,
    output flush, mem_busy,
    input  fwd_sel, stall_if_id, bubble_ex,
    input  freeze, state, stall_cnt
  );

  modport slave (
    input  id_valid, id_src, id_src_used,
    input  id_rd, id_wr_en, id_mem_read,
    input  flush, mem_busy,
    output fwd_sel, stall_if_id, bubble_ex,
    output freeze, state, stall_cnt
  );
`else
  modport master (
    output id_valid, id_src, id_src_used,
    output id_rd, id_wr_en, id_mem_read,
    output flush, mem_busy,
    input  fwd_sel, stall_if_id, bubble_ex,
    input  freeze, state
  );

  modport slave (
    input  id_valid, id_src, id_src_used,
    input  id_rd, id_wr_en, id_mem_read,
    input  flush, mem_busy,
    output fwd_sel, stall_if_id, bubble_ex,
    output freeze, state
  );
`endif

endinterface

// File: rtl/hfu_src_match.sv
// Priority match of one source operand against the shadow stages.
// Ports: src/used in, ent shadow in, sel and load_hit out.
module hfu_src_match
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_AW    = 3,
  parameter int FWD_DEPTH = 2,
  parameter int SELW      = 2
) (
  input  logic [REG_AW-1:0]       src,
  input  logic                    used,
  input  shadow_t [FWD_DEPTH:1]   ent,
  output logic [SELW-1:0]         sel,
  output logic                    load_hit
);

  logic [FWD_DEPTH:1] hit;

  for (genvar k = 1; k <= FWD_DEPTH; k++) begin : g_hit
    assign hit[k] = used & ent[k].valid & ent[k].wr_en
                  & (ent[k].rd == RD_MAXW'(src));
  end

  // Scan oldest to youngest so the youngest match wins.
  // A load in EX has no result yet and is skipped.
  always_comb begin
    sel = SELW'(FWD_SEL_RF);
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (hit[k] && !(k == 1 && ent[k].mem_read))
        sel = SELW'(k);
    end
  end

  assign load_hit = hit[1] & ent[1].mem_read;

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding selects, load-use stall, memory freeze and flush
// control driven by a shadow pipeline of destination tags.
// Ports: clk, rst (sync, active-high), bus (slave modport).
// HFU_PERF_CNT_EN adds a saturating stall/freeze cycle counter.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_AW    = 3,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int SELW      = $clog2(FWD_DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  hazard_forward_unit_if.slave  bus
);

  shadow_t [FWD_DEPTH:1]   ent;
  shadow_t                 id_ent;
  hfu_state_e              st;
  logic [NUM_SRC*SELW-1:0] match_sel;
  logic [NUM_SRC*SELW-1:0] live_sel;
  logic [NUM_SRC*SELW-1:0] held_sel;
  logic [NUM_SRC-1:0]      load_hit;
  logic                    hazard;
  logic                    freeze;
  logic                    stall;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hfu_src_match #(
      .REG_AW    (REG_AW),
      .FWD_DEPTH (FWD_DEPTH),
      .SELW      (SELW)
    ) u_match (
      .src      (bus.id_src[i*REG_AW +: REG_AW]),
      .used     (bus.id_src_used[i]),
      .ent      (ent),
      .sel      (match_sel[i*SELW +: SELW]),
      .load_hit (load_hit[i])
    );
  end

  assign hazard = bus.id_valid & (|load_hit);
  assign freeze = bus.mem_busy | (st == WAIT);
  // Flush and freeze both outrank the load-use stall.
  assign stall  = hazard & ~bus.flush & ~freeze
                & (st == RUN);

  always_comb begin
    live_sel = match_sel;
    if (st == FLUSHED)
      live_sel = {NUM_SRC{SELW'(FWD_SEL_RF)}};
  end

  always_comb begin
    id_ent          = '0;
    id_ent.valid    = bus.id_valid;
    id_ent.wr_en    = bus.id_wr_en;
    id_ent.mem_read = bus.id_mem_read;
    id_ent.rd       = RD_MAXW'(bus.id_rd);
    if (stall)
      id_ent = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent      <= '0;
      st       <= RUN;
      held_sel <= '0;
    end else begin
      // Keeps the select seen on the way into WAIT.
      if (st != WAIT)
        held_sel <= live_sel;
      if (bus.flush) begin
        ent <= '0;
      end else if (!freeze) begin
        for (int k = FWD_DEPTH; k > 1; k--)
          ent[k] <= ent[k-1];
        ent[1] <= id_ent;
      end
      if (bus.flush) begin
        st <= FLUSHED;
      end else begin
        unique case (st)
          RUN:     if (bus.mem_busy) st <= WAIT;
          WAIT:    if (!bus.mem_busy) st <= RUN;
          FLUSHED: st <= bus.mem_busy ? WAIT : RUN;
          default: st <= RUN;
        endcase
      end
    end
  end

  assign bus.fwd_sel     = (st == WAIT) ? held_sel
                                        : live_sel;
  assign bus.stall_if_id = stall;
  assign bus.bubble_ex   = stall;
  assign bus.freeze      = freeze;
  assign bus.state       = st;

`ifdef HFU_PERF_CNT_EN
  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if ((stall | freeze) && cnt != 16'hFFFF)
      cnt <= cnt + 16'd1;
  end

  assign bus.stall_cnt = cnt;
`endif

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised forwarding and hazard unit for the in-order pipeline. It tracks destination tags of in-flight instructions in an internal shadow pipeline of FWD_DEPTH stages, so EX/MEM/WB pipeline registers need not carry tags back to it. Each cycle it issues forwarding selects for NUM_SRC decode-stage source operands. It also controls load-use stalls, memory-wait freezes and flushes. It sits beside the ID/EX pipeline register and drives the EX operand muxes and the IF/ID hold logic.

## Interface
- REG_AW, 3, register address width
- NUM_SRC, 2, source operands checked per instruction (1..4)
- FWD_DEPTH, 2, forwarding stages after ID (2..4); the stage after the last one writes the register file write-before-read
- SELW, $clog2(FWD_DEPTH+1), derived, width of one select field

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  a real instruction occupies ID
- id_src  in  NUM_SRC*REG_AW  packed source addresses, operand i at [i*REG_AW +: REG_AW]
- id_src_used  in  NUM_SRC  operand i is actually read
- id_rd  in  REG_AW  destination of the ID instruction
- id_wr_en  in  1  ID instruction writes the register file
- id_mem_read  in  1  ID instruction is a load
- flush  in  1  kill all in-flight instructions in the shadow pipeline
- mem_busy  in  1  memory stage not ready; whole pipeline holds
- fwd_sel  out  NUM_SRC*SELW  0 = register file, k = result of shadow stage k
- stall_if_id  out  1  hold PC and IF/ID
- bubble_ex  out  1  load a NOP into ID/EX
- freeze  out  1  hold every pipeline register
- state  out  2  FSM state, for debug

## Operation
- Shadow entry: {valid, wr_en, mem_read, rd}. Stage 1 = EX and stage FWD_DEPTH = last forwarding stage.
- Shift: when neither frozen nor stalled, stage k+1 <= stage k and stage 1 <= ID info, valid = id_valid. On stall, stage 1 <= invalid (bubble) and the others still shift.
- Match at stage k for operand i: id_src_used[i] & entry.valid & entry.wr_en & entry.rd == src_i.
- fwd_sel field i = smallest matching k, or 0 if none. Youngest wins. Stage 1 is excluded when its entry has mem_read.
- Load-use hazard: id_valid and any used operand matches stage 1 with mem_read. Effect: stall_if_id = bubble_ex = 1 for that cycle. The next cycle the load sits in stage 2 and the select is 2.
- Register 0 is forwarded like any other register; there is no hardwired zero.
- FSM:
  - RUN: normal operation. mem_busy moves to WAIT.
  - WAIT: freeze = 1, no shift. fwd_sel is held at the value latched on entry. stall_if_id = bubble_ex = 0. Leaves to RUN in the cycle after mem_busy falls.
  - FLUSHED: entered on flush. All entries are invalidated on the clock edge. One cycle with all selects 0, then RUN.
- Priority: rst > flush > mem_busy > load-use hazard. A flush while mem_busy is high still empties the shadow and goes to FLUSHED, then WAIT if mem_busy is still high.

## Timing
- Reset state: all entries invalid, state = RUN, fwd_sel = 0, stall_if_id = bubble_ex = freeze = 0.
- fwd_sel, stall_if_id and bubble_ex are combinational from the ID inputs and registered entries (same-cycle). freeze is combinational from mem_busy | (state == WAIT).
- Shadow and FSM update on the rising clk edge.
- A load-use stall lasts exactly 1 cycle. Back-to-back loads feeding each other stall once per pair.
- Reset asserted mid-WAIT or mid-stall returns to the reset state on that edge.

## Configuration
- HFU_PERF_CNT_EN defined: adds output stall_cnt [15:0], a counter that increments on each cycle with stall_if_id | freeze. It saturates at 16'hFFFF, is cleared by rst and is not cleared by flush.
- Undefined: no counter, no port.

## Structure
- The shared package holds the shadow-entry struct typedef, the FSM state enum (RUN=0, WAIT=1, FLUSHED=2) and the FWD_SEL_RF=0 constant.
- One sub-module, hfu_src_match, holds the per-operand priority match and hazard flag, instantiated NUM_SRC times.

## Test plan
- Defaults: add r3 in ID, the next instruction reads r3 (operand 0) -> fwd_sel[1:0] = 1. One instruction later it would read r3 -> select 2. Two later -> select 0.
- Load r5, then an immediate reader of r5 -> stall_if_id = bubble_ex = 1 for one cycle, then fwd_sel = 2 with no further stall.
- Stage 1 and stage 2 both write r2 and the reader uses r2 on both operands -> both fields = 1.
- mem_busy high for 3 cycles with forwarding active -> freeze = 1 and state = WAIT for the duration, fwd_sel constant. Entries resume shifting the cycle after release.
- flush while a load-use hazard is pending -> no stall. The next cycle state = FLUSHED and all selects are 0.
- FWD_DEPTH=4, NUM_SRC=3 with HFU_PERF_CNT_EN: 70000 freeze cycles -> stall_cnt = 16'hFFFF, and rst clears it to 0.
